mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Multi-cycle controller and iterative datapath for the RV32M multiplies issued by the control unit: MUL, MULH and MULHU.
- Sits in the EX stage beside the ALU.
- On a multiply it takes the EX operands and runs a shift-add sequence of WIDTH steps.
- It holds the pipeline with a stall while it runs, then presents the selected 32-bit result for one cycle.
- The ALU no longer needs combinational multipliers.

Parameters:
WIDTH, 32, operand/result width; must be >= 2.
CNT_W, $clog2(WIDTH)+1, step counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
start_EX  input  1  EX holds a valid instruction this cycle.
aluop_EX  input  4  ALU op from control unit: 0101 MUL, 0110 MULH, 0111 MULHU; other codes are not multiplies.
a_EX  input  WIDTH  rs1 operand.
b_EX  input  WIDTH  rs2 operand.
stall_EX  output  1  freeze PC, fetch and EX pipeline registers.
valid_EX  output  1  result_EX is valid this cycle; writeback uses it.
result_EX  output  WIDTH  multiply result; 0 when valid_EX=0.

Behaviour:
- Clock and reset: one clock domain (clk). Reset (rst) is synchronous and active-high.
- Reset state: state=IDLE; all internal registers 0; stall_EX=0, valid_EX=0, result_EX=0.
- mul_req = start_EX & (aluop_EX in {0101,0110,0111}).
- IDLE:
  - stall_EX = mul_req (combinational, same cycle T).
  - On mul_req: latch op.
  - Signed handling (MULH only): mcand=|a|, mplier=|b|, neg=a[W-1]^b[W-1].
  - MUL/MULHU: raw operands, neg=0. MUL low word is sign-independent.
  - Clear acc (WIDTH+1 bits) and count; go to RUN.
  - Non-multiply ops: no effect, stall_EX=0.
- RUN: stall_EX=1, one step per cycle.
  - If mplier[0], acc = acc + mcand. The add is (WIDTH+1) bits; the carry is kept.
  - Shift {acc,mplier} right by 1.
  - count++. After step WIDTH (count==WIDTH-1 at the edge), go to DONE.
  - RUN lasts exactly WIDTH cycles: T+1..T+WIDTH.
- DONE (cycle T+WIDTH+1): stall_EX=0, valid_EX=1.
  - P = {acc[W-1:0], mplier} (2W bits); P' = neg ? -P : P.
  - result_EX = P'[W-1:0] for MUL, P'[2W-1:W] for MULH/MULHU.
  - start_EX is ignored here: it still reflects the completing instruction.
  - Next state is always IDLE.
- Latency: accept at T, result at T+WIDTH+1. A back-to-back multiply is accepted at T+WIDTH+2.
- Absolute value of -2^(W-1) is 2^(W-1) in W unsigned bits, which is correct. No overflow case exists.
- rst in any state, including mid-RUN: next cycle is IDLE and all outputs are 0. The interrupted multiply is discarded and no valid_EX is produced.
- X on aluop_EX with start_EX=0 must not affect state.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUOP_MUL=4'b0101, ALUOP_MULH=4'b0110, ALUOP_MULHU=4'b0111, so the control unit and this block share one definition.
  - typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_DONE} mulseq_state_t.
- One natural sub-module: mul_shift_add_dp, the acc/mplier/mcand registers, adder, shifter and final negate.
  - Controlled by load/step signals from the FSM in mul_sequencer.

Test Plan:
1. MUL a=7, b=6, start at T -> stall_EX=1 on T..T+32, 0 at T+33; valid_EX=1 only at T+33 with result_EX=0x0000002A.
2. MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. Then MUL with the same operands at T+34 -> result 0x00000001 (confirms back-to-back acceptance).
3. MULH a=b=0x80000000 -> result 0x40000000 (most-negative boundary). MULH a=0xFFFFFFFF, b=0x00000001 -> result 0xFFFFFFFF.
4. MULH a=0xFFFFFFFE(-2), b=0x00000003 -> result 0xFFFFFFFF. MUL with the same operands -> result 0xFFFFFFFA.
5. start_EX=1 with aluop 0011 (ADD) and then 0000 -> stall_EX=0 and valid_EX=0 throughout; state stays IDLE.
6. MUL 0x12345678*0x10 with rst pulsed at RUN cycle 10 -> next cycle stall_EX=0, valid_EX=0, result_EX=0, and no valid pulse at T+33. A fresh MUL 3*5 then returns 0x0000000F after 33 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes for the RV32M multiplies
// and the multiply sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] ALUOP_MUL   = 4'b0101;
  localparam logic [3:0] ALUOP_MULH  = 4'b0110;
  localparam logic [3:0] ALUOP_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mulseq_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_MULH) ||
           (op == ALUOP_MULHU);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: operand registers, WIDTH+1 bit
// accumulator, right shifter and final conditional negate.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             sgn,
  input  logic             hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic               sel_hi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitudes for MULH; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  // One shift-add step and the signed fix-up of the product.
  always_comb begin
    sum    = mplier[0] ? (acc + {1'b0, mcand}) : acc;
    prod   = {acc[WIDTH-1:0], mplier};
    prod_s = neg ? (~prod + 1'b1) : prod;
    result = sel_hi ? prod_s[2*WIDTH-1:WIDTH]
                    : prod_s[WIDTH-1:0];
  end

  // Operand capture on load, {acc,mplier} shift on each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= sgn ? a_mag : a;
      mplier <= sgn ? b_mag : b;
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      sel_hi <= hi;
    end else if (step) begin
      acc    <= {1'b0, sum[WIDTH:1]};
      mplier <= {sum[0], mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multi-cycle multiply sequencer for MUL/MULH/MULHU;
// stalls the pipeline for WIDTH steps then presents the result.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_EX,
  input  logic [3:0]       aluop_EX,
  input  logic [WIDTH-1:0] a_EX,
  input  logic [WIDTH-1:0] b_EX,
  output logic             stall_EX,
  output logic             valid_EX,
  output logic [WIDTH-1:0] result_EX
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mulseq_state_t    state;
  logic [CNT_W-1:0] count;
  logic             done_q;
  logic             mul_req;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] dp_result;

  // Request decode and the stall seen by the rest of the pipe.
  always_comb begin
    mul_req  = start_EX & is_mul_op(aluop_EX);
    load     = (state == MS_IDLE) & mul_req;
    step     = (state == MS_RUN);
    stall_EX = load | step;
  end

  // Sequencer FSM with step counter and registered valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MS_IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        MS_IDLE: begin
          count <= '0;
          if (mul_req) state <= MS_RUN;
        end
        MS_RUN: begin
          if (count == CNT_W'(WIDTH - 1)) begin
            state  <= MS_DONE;
            count  <= '0;
            done_q <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        MS_DONE: state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .sgn    (aluop_EX == ALUOP_MULH),
    .hi     (aluop_EX != ALUOP_MUL),
    .a      (a_EX),
    .b      (b_EX),
    .result (dp_result)
  );

  // Result is only driven during the single valid cycle.
  always_comb begin
    valid_EX  = done_q;
    result_EX = done_q ? dp_result : '0;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer.
// Inputs change #1 after posedge; outputs sampled on negedge.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start_EX;
  logic [3:0]  aluop_EX;
  logic [31:0] a_EX;
  logic [31:0] b_EX;
  logic        stall_EX;
  logic        valid_EX;
  logic [31:0] result_EX;

  int total = 0;
  int bad   = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_EX  (start_EX),
    .aluop_EX  (aluop_EX),
    .a_EX      (a_EX),
    .b_EX      (b_EX),
    .stall_EX  (stall_EX),
    .valid_EX  (valid_EX),
    .result_EX (result_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue at cycle T, hold start through run; check each cycle.
  task automatic run_mul(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    start_EX = 1'b1;
    aluop_EX = op;
    a_EX     = a;
    b_EX     = b;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      if (k < 33) begin
        chk({tag, "_stall"}, {31'b0, stall_EX}, 32'd1);
        chk({tag, "_nvld"}, {31'b0, valid_EX}, 32'd0);
      end else begin
        chk({tag, "_stall_end"}, {31'b0, stall_EX}, 32'd0);
        chk({tag, "_valid"}, {31'b0, valid_EX}, 32'd1);
        chk({tag, "_res"}, result_EX, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    start_EX = 1'b0;
    aluop_EX = 4'b0000;
    a_EX     = '0;
    b_EX     = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_EX}, 32'd0);
    chk("rst_valid", {31'b0, valid_EX}, 32'd0);
    chk("rst_res", result_EX, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_mul("mul7x6", 4'b0101, 32'd7, 32'd6, 32'h0000002A);
    start_EX = 1'b0;
    tick();

    run_mul("mulhu_ff", 4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE);
    run_mul("mul_b2b", 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000001);
    run_mul("mulh_min", 4'b0110, 32'h80000000, 32'h80000000,
            32'h40000000);
    run_mul("mulh_m1", 4'b0110, 32'hFFFFFFFF, 32'h00000001,
            32'hFFFFFFFF);
    run_mul("mulh_m2", 4'b0110, 32'hFFFFFFFE, 32'h00000003,
            32'hFFFFFFFF);
    run_mul("mul_m2", 4'b0101, 32'hFFFFFFFE, 32'h00000003,
            32'hFFFFFFFA);
    start_EX = 1'b0;
    tick();

    start_EX = 1'b1;
    a_EX     = 32'd9;
    b_EX     = 32'd4;
    for (int k = 0; k < 6; k++) begin
      aluop_EX = (k < 3) ? 4'b0011 : 4'b0000;
      @(negedge clk);
      chk("nonmul_stall", {31'b0, stall_EX}, 32'd0);
      chk("nonmul_valid", {31'b0, valid_EX}, 32'd0);
      tick();
    end
    start_EX = 1'b0;
    aluop_EX = 4'bxxxx;
    tick();
    @(negedge clk);
    chk("x_idle_stall", {31'b0, stall_EX}, 32'd0);
    tick();

    // MUL interrupted by reset during RUN cycle 10.
    start_EX = 1'b1;
    aluop_EX = 4'b0101;
    a_EX     = 32'h12345678;
    b_EX     = 32'h00000010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_stall", {31'b0, stall_EX}, 32'd1);
      tick();
    end
    rst      = 1'b1;
    start_EX = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stall0", {31'b0, stall_EX}, 32'd0);
    chk("abort_valid0", {31'b0, valid_EX}, 32'd0);
    chk("abort_res0", result_EX, 32'd0);
    tick();
    for (int k = 12; k <= 36; k++) begin
      @(negedge clk);
      chk("abort_novalid", {31'b0, valid_EX}, 32'd0);
      tick();
    end

    run_mul("mul3x5", 4'b0101, 32'd3, 32'd5, 32'h0000000F);
    start_EX = 1'b0;
    tick();
    @(negedge clk);
    chk("final_idle", {31'b0, stall_EX}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
